// File: rtl/sgdma_desc_pkg.sv
// Shared types and constants for the SGDMA descriptor fetch engine.
// Descriptor is 4 words: src, dst, next byte pointer, {control, status, length}.
package sgdma_desc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_PRESENT,
    ST_WAIT_CMPL,
    ST_WRITEBACK,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int WORD_SRC  = 0;
  localparam int WORD_DST  = 1;
  localparam int WORD_NEXT = 2;
  localparam int WORD_CTRL = 3;

  localparam int CTRL_LSB   = 24;
  localparam int STATUS_LSB = 16;
  localparam int LEN_LSB    = 0;
  localparam int LEN_W      = 16;

  localparam int OWNED_BIT_DEFAULT = 7;

  localparam logic [3:0] BE_ALL       = 4'hF;
  localparam logic [3:0] BE_WRITEBACK = 4'b1100;

  // Upper half of the control word: ownership released, status filled in.
  function automatic logic [31:0] wb_word(input logic [7:0] control,
                                          input logic [7:0] status,
                                          input int         owned_bit);
    logic [7:0] ctrl_clr;
    ctrl_clr = control & ~(8'h01 << owned_bit);
    return {ctrl_clr, status, 16'h0000};
  endfunction

endpackage

// File: rtl/sgdma_descriptor_fetch_if.sv
// Memory-master, descriptor-out and completion-in signals of the fetch engine.
interface sgdma_descriptor_fetch_if #(parameter int ADDR_W = 10);

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;

  logic              desc_valid;
  logic              desc_ready;
  logic [31:0]       desc_src;
  logic [31:0]       desc_dst;
  logic [15:0]       desc_length;
  logic [7:0]        desc_control;

  logic              cmpl_valid;
  logic [7:0]        cmpl_status;
  logic              cmpl_ready;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken,
    input  mem_readdata,
    output desc_valid, desc_src, desc_dst, desc_length, desc_control,
    input  desc_ready,
    input  cmpl_valid, cmpl_status,
    output cmpl_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken,
    output mem_readdata,
    input  desc_valid, desc_src, desc_dst, desc_length, desc_control,
    output desc_ready,
    output cmpl_valid, cmpl_status,
    input  cmpl_ready
  );

endinterface

// File: rtl/sgdma_desc_rd_pipe.sv
// Reads 4 consecutive words starting at base; data returns one cycle after its address.
// Busy for 5 cycles after start; done is high in the last (capture-only) cycle.
module sgdma_desc_rd_pipe #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [31:0]       rdata,
  output logic [ADDR_W-1:0] address,
  output logic              rd,
  output logic              done,
  output logic [3:0][31:0]  words
);

  logic       active;
  logic [2:0] phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      phase  <= 3'd0;
      words  <= '0;
    end else begin
      if (start) begin
        active <= 1'b1;
        phase  <= 3'd0;
      end else if (active) begin
        phase <= phase + 3'd1;
        if (phase == 3'd4) active <= 1'b0;
      end
      // phase 1..4 carries the word addressed in phase 0..3
      if (active && phase != 3'd0) words[phase[1:0] - 2'd1] <= rdata;
    end
  end

  assign address = base + ADDR_W'(phase);
  assign rd      = active && (phase < 3'd4);
  assign done    = active && (phase == 3'd4);

endmodule

// File: rtl/sgdma_descriptor_fetch.sv
// Walks a linked list of descriptors, presents each to the datapath, writes back status.
// Releases ownership on writeback; abort is honoured in CHECK and NEXT only.
module sgdma_descriptor_fetch
  import sgdma_desc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_CHAIN = 256,
  parameter int OWNED_BIT = OWNED_BIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        head_ptr,
  input  logic                     abort,
  output logic                     busy,
  output logic                     chain_done,
  output logic                     chain_err,
  sgdma_descriptor_fetch_if.master bus
);

  localparam int CNT_W = $clog2(MAX_CHAIN + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        status;

  logic [ADDR_W-1:0] rd_address;
  logic              rd_active;
  logic              rd_done;
  logic              rd_start;
  logic [3:0][31:0]  words;
  logic [7:0]        control;
  logic              owned;
  logic              at_limit;
  logic              unused_bits;

  assign control  = words[WORD_CTRL][CTRL_LSB +: 8];
  assign owned    = control[OWNED_BIT];
  assign at_limit = (count == CNT_W'(MAX_CHAIN));
  assign rd_start = (state_nxt == ST_FETCH) && (state != ST_FETCH);

  assign unused_bits = ^{words[WORD_NEXT][31:ADDR_W+2], words[WORD_NEXT][1:0],
                         words[WORD_CTRL][STATUS_LSB +: 8]};

  sgdma_desc_rd_pipe #(.ADDR_W(ADDR_W)) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .start   (rd_start),
    .base    (ptr),
    .rdata   (bus.mem_readdata),
    .address (rd_address),
    .rd      (rd_active),
    .done    (rd_done),
    .words   (words)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_FETCH;
      ST_FETCH:     if (rd_done) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!owned || abort || at_limit) state_nxt = ST_DONE;
        else                             state_nxt = ST_PRESENT;
      end
      ST_PRESENT:   if (bus.desc_ready) state_nxt = ST_WAIT_CMPL;
      ST_WAIT_CMPL: if (bus.cmpl_valid) state_nxt = ST_WRITEBACK;
      ST_WRITEBACK: state_nxt = ST_NEXT;
      ST_NEXT:      state_nxt = abort ? ST_DONE : ST_FETCH;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_address    = '0;
    bus.mem_chipselect = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_byteenable = BE_ALL;
    bus.mem_writedata  = '0;
    bus.desc_valid     = 1'b0;
    bus.cmpl_ready     = 1'b0;
    chain_done         = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.mem_chipselect = rd_active;
        bus.mem_address    = rd_active ? rd_address : '0;
      end
      ST_PRESENT:   bus.desc_valid = 1'b1;
      ST_WAIT_CMPL: bus.cmpl_ready = 1'b1;
      ST_WRITEBACK: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_write      = 1'b1;
        bus.mem_address    = ptr + ADDR_W'(WORD_CTRL);
        bus.mem_byteenable = BE_WRITEBACK;
        bus.mem_writedata  = wb_word(control, status, OWNED_BIT);
      end
      ST_DONE:      chain_done = 1'b1;
      default: ;
    endcase
  end

  assign busy             = (state != ST_IDLE);
  assign bus.mem_clken    = 1'b1;
  assign bus.desc_src     = words[WORD_SRC];
  assign bus.desc_dst     = words[WORD_DST];
  assign bus.desc_length  = words[WORD_CTRL][LEN_LSB +: LEN_W];
  assign bus.desc_control = control;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      status    <= '0;
      chain_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          ptr       <= head_ptr;
          count     <= '0;
          chain_err <= 1'b0;
        end
        ST_CHECK: if (owned && !abort) begin
          if (at_limit) chain_err <= 1'b1;
          else          count     <= count + 1'b1;
        end
        ST_WAIT_CMPL: if (bus.cmpl_valid) status <= bus.cmpl_status;
        ST_NEXT:      ptr <= words[WORD_NEXT][ADDR_W+1:2];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sgdma_descriptor_fetch.sv
// Directed bench: behavioural 1-cycle-latency memory plus hand-computed expectations.
module tb_sgdma_descriptor_fetch;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] head_ptr;
  logic       abort;
  logic       busy;
  logic       chain_done;
  logic       chain_err;

  sgdma_descriptor_fetch_if #(.ADDR_W(10)) bus ();

  sgdma_descriptor_fetch #(.ADDR_W(10), .MAX_CHAIN(4), .OWNED_BIT(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .head_ptr   (head_ptr),
    .abort      (abort),
    .busy       (busy),
    .chain_done (chain_done),
    .chain_err  (chain_err),
    .bus        (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] rdata;
  logic        host_we;
  logic [9:0]  host_addr;
  logic [31:0] host_data;
  logic        reown;
  int          rd_cnt = 0;
  int          wb_cnt = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic [9:0]  rd_log [0:63];
  logic [31:0] be_mask;

  always #5 clk = ~clk;

  assign bus.mem_readdata = rdata;
  assign be_mask = {{8{bus.mem_byteenable[3]}}, {8{bus.mem_byteenable[2]}},
                    {8{bus.mem_byteenable[1]}}, {8{bus.mem_byteenable[0]}}};

  // Memory model, with an optional "software re-owns on writeback" hook.
  always @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_data;
    if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write) begin
        mem[bus.mem_address] <= (mem[bus.mem_address] & ~be_mask) | (bus.mem_writedata & be_mask)
                                | (reown ? 32'h8000_0000 : 32'h0);
        wb_cnt <= wb_cnt + 1;
      end else begin
        rdata <= mem[bus.mem_address];
        rd_log[rd_cnt % 64] <= bus.mem_address;
        rd_cnt <= rd_cnt + 1;
      end
    end
    if (bus.desc_valid && bus.desc_ready) hs_cnt <= hs_cnt + 1;
    if (chain_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [9:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_data = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic put_desc(input logic [9:0] p, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] nxt, input logic [31:0] w3);
    host_write(p, s);
    host_write(p + 10'd1, d);
    host_write(p + 10'd2, nxt);
    host_write(p + 10'd3, w3);
  endtask

  task automatic pulse_start(input logic [9:0] p);
    start = 1'b1; head_ptr = p;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.desc_valid && n < 60) begin tick(); n++; end
    chk({tag, "_valid"}, bus.desc_valid, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!chain_done && n < 60) begin tick(); n++; end
    chk({tag, "_done"}, chain_done, 1);
  endtask

  // Handshake one descriptor and complete it; returns in the WRITEBACK cycle.
  task automatic run_desc(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] len, input logic [7:0] st);
    wait_valid(tag);
    chk({tag, "_src"}, bus.desc_src, s);
    chk({tag, "_dst"}, bus.desc_dst, d);
    chk({tag, "_len"}, {16'h0, bus.desc_length}, {16'h0, len});
    bus.desc_ready = 1'b1; tick(); bus.desc_ready = 1'b0;
    chk({tag, "_cmpl_ready"}, bus.cmpl_ready, 1);
    bus.cmpl_status = st; bus.cmpl_valid = 1'b1; tick(); bus.cmpl_valid = 1'b0;
    chk({tag, "_wb_we_be"}, {27'h0, bus.mem_write, bus.mem_byteenable}, 32'h1C);
  endtask

  initial begin
    int lat, hs0, wb0, rd0, dn0;
    logic stable;
    clk = 1'b0; reset = 1'b1; start = 1'b0; head_ptr = '0; abort = 1'b0;
    host_we = 1'b0; host_addr = '0; host_data = '0; reown = 1'b0; rdata = '0;
    bus.desc_ready = 1'b0; bus.cmpl_valid = 1'b0; bus.cmpl_status = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_flags", {chain_done, chain_err, bus.desc_valid, bus.cmpl_ready}, 0);
    chk("rst_mem_ctl", {bus.mem_clken, bus.mem_byteenable, bus.mem_chipselect, bus.mem_write}, 32'h7C);
    chk("rst_mem_addr_wd", {bus.mem_address, bus.mem_writedata[21:0]}, 0);
    reset = 1'b0;
    tick();

    // Single descriptor at 0x010, followed by an unowned one at 0x000.
    put_desc(10'h010, 32'h1000, 32'h2000, 32'h0, 32'h8000_0040);
    put_desc(10'h000, 32'h0, 32'h0, 32'h0, 32'h0);
    pulse_start(10'h010);
    chk("t1_busy", busy, 1);
    lat = 1;
    while (!bus.desc_valid && lat < 30) begin tick(); lat++; end
    chk("t1_latency", 32'(lat), 7);
    chk("t1_src", bus.desc_src, 32'h1000);
    chk("t1_dst", bus.desc_dst, 32'h2000);
    chk("t1_len_ctrl", {bus.desc_control, bus.desc_length}, 32'h80_0040);
    bus.desc_ready = 1'b1; tick(); bus.desc_ready = 1'b0;
    bus.cmpl_status = 8'h5A; bus.cmpl_valid = 1'b1; tick(); bus.cmpl_valid = 1'b0;
    chk("t1_wb_addr", {22'h0, bus.mem_address}, 32'h013);
    chk("t1_wb_data", bus.mem_writedata, 32'h005A_0000);
    chk("t1_wb_be", {28'h0, bus.mem_byteenable}, 32'hC);
    wait_done("t1");
    chk("t1_mem13", mem[10'h013], 32'h005A_0040);
    tick();
    chk("t1_idle", {busy, chain_done, chain_err}, 0);

    // Three-descriptor chain ending at an unowned descriptor.
    put_desc(10'h000, 32'hA0, 32'hB0, 32'h10, 32'h8000_0010);
    put_desc(10'h004, 32'hC0, 32'hD0, 32'h20, 32'h8000_0020);
    put_desc(10'h008, 32'hE0, 32'hF0, 32'h30, 32'h8000_0030);
    put_desc(10'h00C, 32'h0, 32'h0, 32'h0, 32'h0);
    hs0 = hs_cnt; wb0 = wb_cnt; dn0 = done_cnt;
    pulse_start(10'h000);
    run_desc("t2a", 32'hA0, 32'hB0, 16'h10, 8'h31);
    lat = 1;
    while (!bus.desc_valid && lat < 30) begin tick(); lat++; end
    chk("t2_cmpl_to_valid", 32'(lat), 9);
    run_desc("t2b", 32'hC0, 32'hD0, 16'h20, 8'h32);
    run_desc("t2c", 32'hE0, 32'hF0, 16'h30, 8'h33);
    wait_done("t2");
    tick();
    chk("t2_handshakes", 32'(hs_cnt - hs0), 3);
    chk("t2_writebacks", 32'(wb_cnt - wb0), 3);
    chk("t2_done_pulses", 32'(done_cnt - dn0), 1);
    chk("t2_err", chain_err, 0);
    chk("t2_mem0b", mem[10'h00B], 32'h0033_0030);

    // Address wrap at the top of memory.
    put_desc(10'h3FE, 32'h3000, 32'h4000, 32'h100, 32'h8000_0008);
    put_desc(10'h040, 32'h0, 32'h0, 32'h0, 32'h0);
    rd0 = rd_cnt;
    pulse_start(10'h3FE);
    run_desc("t3", 32'h3000, 32'h4000, 16'h8, 8'h11);
    chk("t3_wb_addr", {22'h0, bus.mem_address}, 32'h001);
    chk("t3_rd_addrs", {rd_log[rd0 % 64], rd_log[(rd0 + 1) % 64], rd_log[(rd0 + 2) % 64]},
        {10'h3FE, 10'h3FF, 10'h000});
    chk("t3_rd_addr3", {22'h0, rd_log[(rd0 + 3) % 64]}, 32'h001);
    wait_done("t3");
    chk("t3_mem1", mem[10'h001], 32'h0011_0008);
    tick();

    // Self-referencing descriptor kept owned; chain limit is 4. A start mid-chain is ignored.
    put_desc(10'h020, 32'h9000, 32'h9100, 32'h80, 32'h8000_0004);
    reown = 1'b1;
    hs0 = hs_cnt;
    pulse_start(10'h020);
    run_desc("t4a", 32'h9000, 32'h9100, 16'h4, 8'h01);
    pulse_start(10'h010);
    run_desc("t4b", 32'h9000, 32'h9100, 16'h4, 8'h02);
    run_desc("t4c", 32'h9000, 32'h9100, 16'h4, 8'h03);
    run_desc("t4d", 32'h9000, 32'h9100, 16'h4, 8'h04);
    wait_done("t4");
    chk("t4_err", chain_err, 1);
    chk("t4_handshakes", 32'(hs_cnt - hs0), 4);
    tick();
    reown = 1'b0;
    chk("t4_err_sticky", {busy, chain_err}, 32'h1);

    // Backpressure, then abort while waiting for completion.
    put_desc(10'h030, 32'h5555, 32'h6666, 32'hD0, 32'h8000_0100);
    put_desc(10'h034, 32'h7777, 32'h8888, 32'h0, 32'h8000_0004);
    rd0 = rd_cnt;
    pulse_start(10'h030);
    chk("t5_err_cleared", chain_err, 0);
    wait_valid("t5");
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.desc_valid || bus.desc_src !== 32'h5555 || bus.desc_dst !== 32'h6666 ||
          bus.desc_length !== 16'h0100) stable = 1'b0;
    end
    chk("t5_stable", stable, 1);
    bus.desc_ready = 1'b1; tick(); bus.desc_ready = 1'b0;
    abort = 1'b1;
    tick(); tick(); tick();
    chk("t5_still_waiting", bus.cmpl_ready, 1);
    bus.cmpl_status = 8'hEE; bus.cmpl_valid = 1'b1; tick(); bus.cmpl_valid = 1'b0;
    chk("t5_wb", {bus.mem_write, bus.mem_address}, {1'b1, 10'h033});
    tick();
    chk("t5_next_not_done", chain_done, 0);
    tick();
    chk("t5_done", chain_done, 1);
    abort = 1'b0;
    tick();
    chk("t5_idle", busy, 0);
    chk("t5_reads", 32'(rd_cnt - rd0), 4);
    chk("t5_mem33", mem[10'h033], 32'h00EE_0100);

    // Synchronous reset in the WRITEBACK cycle, then a fresh start.
    host_write(10'h033, 32'h8000_0100);
    pulse_start(10'h030);
    run_desc("t6", 32'h5555, 32'h6666, 16'h0100, 8'h22);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_after_rst", {bus.mem_write, bus.mem_chipselect, busy, chain_done, bus.cmpl_ready}, 0);
    host_write(10'h033, 32'h8000_0100);
    pulse_start(10'h030);
    chk("t6_busy", busy, 1);
    lat = 1;
    while (!bus.desc_valid && lat < 30) begin tick(); lat++; end
    chk("t6_latency", 32'(lat), 7);
    run_desc("t6b", 32'h5555, 32'h6666, 16'h0100, 8'h23);
    abort = 1'b1;
    wait_done("t6");
    abort = 1'b0;
    tick();
    chk("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
